// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase traffic signal controller.
// Each phase runs GREEN -> YELLOW -> ALLRED. Phases with no pending call are
// skipped. All timing counts in units of the external tick strobe. With no
// call pending on another phase, the controller rests in GREEN.
// Optional pedestrian support is enabled by defining TRAFFIC_PED_EN.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES  = 4,
  parameter int TIMER_WIDTH = 6,
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 3,
  parameter int CLEAR_TIME  = 1,
  parameter int WALK_TIME   = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [NUM_PHASES-1:0]         demand,
  input  logic [3:0]                    extend,
`ifdef TRAFFIC_PED_EN
  input  logic [NUM_PHASES-1:0]         ped_req,
  output logic [NUM_PHASES-1:0]         ped_walk,
`endif
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase
);

  localparam int AW = $clog2(NUM_PHASES);
  localparam int DW = TIMER_WIDTH + 1;
  localparam int unsigned NP = NUM_PHASES;

  if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_num_phases
    $error("NUM_PHASES must be in 2..8");
  end
  if (GREEN_TIME < 1 || YELLOW_TIME < 1 || CLEAR_TIME < 1) begin : g_bad_times
    $error("GREEN_TIME, YELLOW_TIME and CLEAR_TIME must be >= 1");
  end
  if (WALK_TIME < 1 || WALK_TIME > GREEN_TIME) begin : g_bad_walk
    $error("WALK_TIME must be in 1..GREEN_TIME");
  end

  typedef enum logic [1:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          active_q, active_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [NUM_PHASES-1:0]  calls_q, calls_d;

  logic [DW-1:0]          dur;
  logic [DW-1:0]          term;
  logic                   expired;
  logic [NUM_PHASES-1:0]  active_oh;
  logic [NUM_PHASES-1:0]  next_oh;
  logic [NUM_PHASES-1:0]  pending;
  logic [NUM_PHASES-1:0]  others;
  logic [NUM_PHASES-1:0]  calls_clr;
  logic [NUM_PHASES-1:0]  dmd_mask;
  logic [AW-1:0]          next_phase;
  logic                   found;

`ifdef TRAFFIC_PED_EN
  logic [NUM_PHASES-1:0]  ped_q, ped_d;
  logic                   walk_q, walk_d;
`endif

  // Pending demand seen by phase selection and dwell exit
  always_comb begin
`ifdef TRAFFIC_PED_EN
    pending = calls_q | ped_q;
`else
    pending = calls_q;
`endif
  end

  // Current state duration, terminal timer value and expiry strobe
  always_comb begin
    unique case (state_q)
      ST_GREEN:  dur = DW'(GREEN_TIME) + DW'(extend);
      ST_YELLOW: dur = DW'(YELLOW_TIME);
      default:   dur = DW'(CLEAR_TIME);
    endcase
    term = dur - DW'(1);
    // >= rather than == so a shrinking extend during dwell cannot strand the timer
    expired = tick && ({1'b0, timer_q} >= term);
  end

  // One-hot of the active phase and round-robin search for the next caller
  always_comb begin
    active_oh  = '0;
    active_oh[active_q] = 1'b1;
    next_phase = AW'((32'(active_q) + 32'd1) % NP);
    found      = 1'b0;
    for (int unsigned k = 1; k <= NP; k++) begin
      if (!found && pending[AW'((32'(active_q) + k) % NP)]) begin
        next_phase = AW'((32'(active_q) + k) % NP);
        found      = 1'b1;
      end
    end
    next_oh = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      next_oh[i] = (AW'(i) == next_phase);
    end
  end

  // Next-state, timer and call-register logic
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    timer_d   = timer_q;
    calls_clr = '0;
    others    = pending & ~active_oh;
`ifdef TRAFFIC_PED_EN
    walk_d    = walk_q;
`endif

    unique case (state_q)
      ST_GREEN: begin
        if (expired && (|others)) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (expired) begin
          state_d = ST_ALLRED;
        end
      end
      default: begin
        if (expired) begin
          state_d   = ST_GREEN;
          active_d  = next_phase;
          calls_clr = next_oh;
        end
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && ({1'b0, timer_q} < term)) begin
      timer_d = timer_q + 1'b1;
    end

    // The active phase's own call is meaningless while it already has green
    dmd_mask = (state_q == ST_GREEN) ? ~active_oh : '1;
    calls_d  = (calls_q & ~calls_clr) | (demand & dmd_mask);

`ifdef TRAFFIC_PED_EN
    ped_d = (ped_q & ~calls_clr) | (ped_req & dmd_mask);
    if (state_q == ST_ALLRED && state_d == ST_GREEN) begin
      walk_d = |(ped_q & next_oh);
    end else if (state_d != ST_GREEN) begin
      walk_d = 1'b0;
    end else if (tick && timer_q == TIMER_WIDTH'(WALK_TIME - 1)) begin
      walk_d = 1'b0;
    end
`endif
  end

  // State registers; reset puts phase 0 straight into green
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_GREEN;
      active_q <= '0;
      timer_q  <= '0;
      calls_q  <= '0;
`ifdef TRAFFIC_PED_EN
      ped_q    <= '0;
      walk_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      timer_q  <= timer_d;
      calls_q  <= calls_d;
`ifdef TRAFFIC_PED_EN
      ped_q    <= ped_d;
      walk_q   <= walk_d;
`endif
    end
  end

  // Lamp decode from registered state only
  always_comb begin
    lights = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (state_q != ST_ALLRED && AW'(i) == active_q) begin
        lights[3*i +: 3] = (state_q == ST_GREEN) ? 3'b001 : 3'b010;
      end else begin
        lights[3*i +: 3] = 3'b100;
      end
    end
    active_phase = active_q;
`ifdef TRAFFIC_PED_EN
    ped_walk = (walk_q && state_q == ST_GREEN) ? active_oh : '0;
`endif
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised N-phase traffic signal controller, the next-generation successor to the team's fixed two-road controller. It sequences any number of conflicting phases through green, yellow and all-red clearance, and it skips phases that have no demand. It times in units of an external `tick` strobe instead of raw clock cycles, and it rests in green when no other phase is calling. It sits between the sensor/switch debounce logic and the lamp driver outputs on the board top level.

## Interface
Parameters:
- `NUM_PHASES`, 4: number of phases; legal range 2..8.
- `TIMER_WIDTH`, 6: tick counter width; `GREEN_TIME+15` must fit in it.
- `GREEN_TIME`, 20: base green duration in ticks; must be ≥1.
- `YELLOW_TIME`, 3: yellow duration in ticks; must be ≥1.
- `CLEAR_TIME`, 1: all-red clearance in ticks; must be ≥1.
- `WALK_TIME`, 7: walk indication in ticks; only used with `TRAFFIC_PED_EN`; must be ≤ `GREEN_TIME`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: single-cycle time-unit strobe; all timing advances only on cycles with `tick`=1.
- `demand` in `NUM_PHASES`: vehicle call per phase, level or pulse.
- `extend` in 4: unsigned number of ticks added to `GREEN_TIME`.
- `lights` out `3*NUM_PHASES`: phase i drives bits [3i+2:3i] as {R,Y,G}.
- `active_phase` out `$clog2(NUM_PHASES)`: index of the phase currently owning right-of-way.
- `ped_req` in `NUM_PHASES`: pedestrian call per phase. Present only with `TRAFFIC_PED_EN`.
- `ped_walk` out `NUM_PHASES`: walk lamp per phase. Present only with `TRAFFIC_PED_EN`.

## Operation
- The FSM states are GREEN, YELLOW and ALLRED, each applied to the active phase. Every non-active phase always shows R (3'b100).
- Lamp outputs:
  - In GREEN, the active phase shows 3'b001.
  - In YELLOW, the active phase shows 3'b010.
  - In ALLRED, every phase shows 3'b100.
- Call register `calls[NUM_PHASES]`:
  - Bit i is set on any cycle with `demand[i]`=1.
  - Set has priority over clear.
  - `demand[active_phase]` is ignored while in GREEN.
  - Bit i is cleared on the cycle the controller enters GREEN for phase i.
- Timer:
  - Cleared on every state change.
  - Otherwise increments on `tick` and saturates at its terminal value.
  - A state expires on a cycle where `tick`=1 and timer = duration−1.
- Durations:
  - GREEN = `GREEN_TIME + extend`, computed at `TIMER_WIDTH+1` bits. `extend` is sampled continuously, not latched.
  - YELLOW = `YELLOW_TIME`.
  - ALLRED = `CLEAR_TIME`.
- Transitions:
  - GREEN→YELLOW when GREEN has expired and any other phase has a pending call.
  - With no pending calls, GREEN dwells with the timer held at its terminal value. It leaves for YELLOW on the first `tick` after a call appears.
  - YELLOW→ALLRED on expiry.
  - ALLRED→GREEN on expiry. The next phase is the first phase with a pending call, searching from active+1 upward and wrapping modulo `NUM_PHASES`.
  - If all calls vanished before ALLRED expires (not possible by construction), the next phase is active+1.
- Reset: phase 0 enters GREEN, the timer is 0, all calls are 0, `active_phase`=0, and `ped_walk`=0.
- Reset asserted mid-cycle forces the reset state immediately and asynchronously, with no yellow or all-red interval.

## Timing
- All outputs are registered or decoded purely from registered state; there is no combinational input→output path.
- A state change occurs on the clock edge of the expiring `tick` cycle. Lamps update in the same cycle the state register updates.
- A `demand` pulse of one cycle is sufficient to register a call. It becomes visible to the transition logic in the next cycle.
- `tick` asserted on consecutive cycles is legal; each assertion counts as one time unit.

## Configuration
- `TRAFFIC_PED_EN` defined:
  - `ped_req` and `ped_walk` ports exist. `ped_req[i]` sets a separate pedestrian call bit.
  - A pedestrian call counts as demand for phase selection and dwell exit.
  - On entering GREEN for phase i with a pedestrian call pending, `ped_walk[i]`=1 for the first `WALK_TIME` ticks of that green, then returns to 0. The pedestrian call clears on entry.
  - `ped_walk` is never 1 outside GREEN.
- `TRAFFIC_PED_EN` undefined: no pedestrian ports and no pedestrian state are present. Behaviour is otherwise identical.

## Test plan
- Defaults, `extend`=0, `tick` every cycle, `demand`=4'b0010 pulsed at cycle 2:
  - phase 0 is green for 20 ticks, then yellow for 3, then all-red for 1;
  - phase 1 then goes green, and `lights[5:3]`=3'b001.
- No demand for 100 ticks after reset → phase 0 stays green and `active_phase`=0 throughout.
- `demand`=4'b1001 while phase 1 is green → the next green is phase 3 (phase 2 skipped), followed by phase 0.
- `extend`=4'd15 → phase 0 green lasts exactly 35 ticks before yellow when a call is pending.
- `rst_n` dropped during YELLOW → on the same cycle, `lights` shows phase 0 green (3'b001) and all others red, with no clock edge needed.
- With `TRAFFIC_PED_EN`, `ped_req[2]` pulsed alone → phase 2 gets green with `ped_walk[2]`=1 for 7 ticks, then 0 while green continues.
